// File: rtl/ex_pkg.sv
// Shared widths, ALU operation/class encodings and the muldiv FSM state type
// for the execute stage and its neighbours.
package ex_pkg;
  localparam int RegLen     = 32;
  localparam int RegAddrLen = 5;
  localparam int OpCodeLen  = 8;
  localparam int OpSelLen   = 3;
  localparam logic ResetEnable = 1'b1;

  localparam logic [OpSelLen-1:0] SEL_NOP    = 3'd0;
  localparam logic [OpSelLen-1:0] SEL_LOGIC  = 3'd1;
  localparam logic [OpSelLen-1:0] SEL_SHIFT  = 3'd2;
  localparam logic [OpSelLen-1:0] SEL_ARITH  = 3'd3;
  localparam logic [OpSelLen-1:0] SEL_MULDIV = 3'd4;

  localparam logic [OpCodeLen-1:0] OP_AND    = 8'd1;
  localparam logic [OpCodeLen-1:0] OP_OR     = 8'd2;
  localparam logic [OpCodeLen-1:0] OP_XOR    = 8'd3;
  localparam logic [OpCodeLen-1:0] OP_SLL    = 8'd4;
  localparam logic [OpCodeLen-1:0] OP_SRL    = 8'd5;
  localparam logic [OpCodeLen-1:0] OP_SRA    = 8'd6;
  localparam logic [OpCodeLen-1:0] OP_ADD    = 8'd7;
  localparam logic [OpCodeLen-1:0] OP_SUB    = 8'd8;
  localparam logic [OpCodeLen-1:0] OP_SLT    = 8'd9;
  localparam logic [OpCodeLen-1:0] OP_SLTU   = 8'd10;
  localparam logic [OpCodeLen-1:0] OP_LUI    = 8'd11;
  localparam logic [OpCodeLen-1:0] OP_MUL    = 8'd12;
  localparam logic [OpCodeLen-1:0] OP_MULH   = 8'd13;
  localparam logic [OpCodeLen-1:0] OP_MULHSU = 8'd14;
  localparam logic [OpCodeLen-1:0] OP_MULHU  = 8'd15;
  localparam logic [OpCodeLen-1:0] OP_DIV    = 8'd16;
  localparam logic [OpCodeLen-1:0] OP_DIVU   = 8'd17;
  localparam logic [OpCodeLen-1:0] OP_REM    = 8'd18;
  localparam logic [OpCodeLen-1:0] OP_REMU   = 8'd19;

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;

  function automatic logic is_muldiv(input logic [OpCodeLen-1:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction
endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 RV32M engine: shift-add multiply, restoring divide,
// 32 iterations on operand magnitudes with sign fix-up in DONE.
module muldiv_unit
  import ex_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [RegLen-1:0]    a,
  input  logic [RegLen-1:0]    b,
  input  logic [OpCodeLen-1:0] op,
  output logic                 busy,
  output logic                 done,
  output logic [RegLen-1:0]    result
);
  md_state_e              state;
  logic [5:0]             cnt;
  logic [63:0]            acc;
  logic [31:0]            opb;
  logic [OpCodeLen-1:0]   op_q;
  logic                   neg_res;

  logic        a_neg, b_neg, div_op, new_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, shl_hi, sub;
  logic [63:0] mul_next, div_next, prod;

  always_comb begin
    a_neg  = a[31] && (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
    b_neg  = b[31] && (op == OP_MULH || op == OP_DIV || op == OP_REM);
    div_op = op >= OP_DIV;
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;
    // Divide-by-zero keeps the all-ones quotient unsigned; remainder follows the dividend.
    if (op == OP_REM || op == OP_REMU) new_neg = a_neg;
    else if (div_op)                   new_neg = (a_neg ^ b_neg) && (b != '0);
    else                               new_neg = a_neg ^ b_neg;
  end

  // Multiply: low half holds the multiplier, shifted out as the product grows.
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
  assign mul_next = {mul_sum, acc[31:1]};
  // Divide: high half is the partial remainder, low half collects quotient bits.
  assign shl_hi   = acc[63:31];
  assign sub      = shl_hi - {1'b0, opb};
  assign div_next = sub[32] ? {acc[62:0], 1'b0} : {sub[31:0], acc[30:0], 1'b1};

  always_ff @(posedge clk) begin
    if (rst == ResetEnable) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      acc     <= '0;
      opb     <= '0;
      op_q    <= '0;
      neg_res <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: if (start) begin
          state   <= MD_BUSY;
          cnt     <= '0;
          acc     <= {32'd0, a_mag};
          opb     <= b_mag;
          op_q    <= op;
          neg_res <= new_neg;
        end
        MD_BUSY: begin
          acc <= (op_q >= OP_DIV) ? div_next : mul_next;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= MD_DONE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign busy = (state == MD_BUSY);
  assign done = (state == MD_DONE);
  assign prod = neg_res ? -acc : acc;

  always_comb begin
    result = '0;
    if (done) begin
      case (op_q)
        OP_MUL:                        result = prod[31:0];
        OP_MULH, OP_MULHSU, OP_MULHU:  result = prod[63:32];
        OP_DIV, OP_DIVU:               result = neg_res ? -acc[31:0] : acc[31:0];
        OP_REM, OP_REMU:               result = neg_res ? -acc[63:32] : acc[63:32];
        default:                       result = '0;
      endcase
    end
  end
endmodule

// File: rtl/ex.sv
// Execute stage: combinational ALU plus the stalling muldiv engine, muxed
// onto the EX/MEM outputs with bubbles while a muldiv is in flight.
module ex
  import ex_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RegLen-1:0]     reg1,
  input  logic [RegLen-1:0]     reg2,
  input  logic [RegLen-1:0]     Imm,
  input  logic [RegAddrLen-1:0] rd,
  input  logic                  rd_enable,
  input  logic [OpCodeLen-1:0]  aluop,
  input  logic [OpSelLen-1:0]   alusel,
  output logic [RegLen-1:0]     rd_data_o,
  output logic [RegAddrLen-1:0] rd_addr_o,
  output logic                  rd_enable_o,
  output logic                  stall_req
);
  logic              md_start, md_busy, md_done, alu_ok;
  logic [RegLen-1:0] md_result, alu_val;

  assign md_start = (alusel == SEL_MULDIV) && is_muldiv(aluop);

  muldiv_unit u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .a      (reg1),
    .b      (reg2),
    .op     (aluop),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  // In DONE the stalled muldiv is still on the inputs; it must not restart.
  assign stall_req = (rst != ResetEnable) && (md_busy || (md_start && !md_done));

  always_comb begin
    alu_val = '0;
    alu_ok  = 1'b1;
    case ({alusel, aluop})
      {SEL_LOGIC, OP_AND}:  alu_val = reg1 & reg2;
      {SEL_LOGIC, OP_OR}:   alu_val = reg1 | reg2;
      {SEL_LOGIC, OP_XOR}:  alu_val = reg1 ^ reg2;
      {SEL_SHIFT, OP_SLL}:  alu_val = reg1 << reg2[4:0];
      {SEL_SHIFT, OP_SRL}:  alu_val = reg1 >> reg2[4:0];
      {SEL_SHIFT, OP_SRA}:  alu_val = $signed(reg1) >>> reg2[4:0];
      {SEL_ARITH, OP_ADD}:  alu_val = reg1 + reg2;
      {SEL_ARITH, OP_SUB}:  alu_val = reg1 - reg2;
      {SEL_ARITH, OP_SLT}:  alu_val = {31'd0, $signed(reg1) < $signed(reg2)};
      {SEL_ARITH, OP_SLTU}: alu_val = {31'd0, reg1 < reg2};
      {SEL_ARITH, OP_LUI}:  alu_val = Imm;
      default:              alu_ok  = 1'b0;
    endcase
  end

  always_comb begin
    rd_data_o   = '0;
    rd_addr_o   = '0;
    rd_enable_o = 1'b0;
    if (rst != ResetEnable) begin
      rd_addr_o = rd;
      if (stall_req) begin
        rd_enable_o = 1'b0;
      end else if (md_done) begin
        rd_data_o   = md_result;
        rd_enable_o = rd_enable;
      end else if (alu_ok) begin
        rd_data_o   = alu_val;
        rd_enable_o = rd_enable;
      end
    end
  end
endmodule

// File: tb/tb_ex.sv
// Randomized bench for ex against a plain-arithmetic reference of the ALU
// and RV32M results, with cycle-exact checks of the muldiv stall window.
module tb_ex;
  import ex_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [RegLen-1:0]     reg1, reg2, Imm;
  logic [RegAddrLen-1:0] rd;
  logic                  rd_enable;
  logic [OpCodeLen-1:0]  aluop;
  logic [OpSelLen-1:0]   alusel;
  logic [RegLen-1:0]     rd_data_o;
  logic [RegAddrLen-1:0] rd_addr_o;
  logic                  rd_enable_o;
  logic                  stall_req;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex dut (
    .clk(clk), .rst(rst), .reg1(reg1), .reg2(reg2), .Imm(Imm), .rd(rd),
    .rd_enable(rd_enable), .aluop(aluop), .alusel(alusel),
    .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o), .rd_enable_o(rd_enable_o),
    .stall_req(stall_req)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Returns {valid, data}; valid=0 means the op writes nothing.
  function automatic logic [32:0] alu_ref(input logic [2:0] sel, input logic [7:0] op,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] imm);
    logic [63:0] ext;
    int sa, sb;
    sa  = a;
    sb  = b;
    ext = {{32{a[31]}}, a} >> b[4:0];
    if (sel == SEL_LOGIC && op == OP_AND)  return {1'b1, a & b};
    if (sel == SEL_LOGIC && op == OP_OR)   return {1'b1, a | b};
    if (sel == SEL_LOGIC && op == OP_XOR)  return {1'b1, a ^ b};
    if (sel == SEL_SHIFT && op == OP_SLL)  return {1'b1, a << b[4:0]};
    if (sel == SEL_SHIFT && op == OP_SRL)  return {1'b1, a >> b[4:0]};
    if (sel == SEL_SHIFT && op == OP_SRA)  return {1'b1, ext[31:0]};
    if (sel == SEL_ARITH && op == OP_ADD)  return {1'b1, a + b};
    if (sel == SEL_ARITH && op == OP_SUB)  return {1'b1, a - b};
    if (sel == SEL_ARITH && op == OP_SLT)  return {1'b1, (sa < sb) ? 32'd1 : 32'd0};
    if (sel == SEL_ARITH && op == OP_SLTU) return {1'b1, (a < b) ? 32'd1 : 32'd0};
    if (sel == SEL_ARITH && op == OP_LUI)  return {1'b1, imm};
    return 33'd0;
  endfunction

  function automatic logic [31:0] md_ref(input logic [7:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] xa, xb, p;
    int sa, sb, q;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    xa  = (op == OP_MULH || op == OP_MULHSU) ? {{32{a[31]}}, a} : {32'd0, a};
    xb  = (op == OP_MULH) ? {{32{b[31]}}, b} : {32'd0, b};
    p   = xa * xb;
    case (op)
      OP_MUL:                       return p[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: return p[63:32];
      OP_DIV:  begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return 32'h8000_0000;
        q = sa / sb;
        return q;
      end
      OP_REM:  begin
        if (b == 0) return a;
        if (ovf)    return 32'd0;
        q = sa % sb;
        return q;
      end
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic [4:0] r,
                       input logic en);
    alusel = sel; aluop = op; reg1 = a; reg2 = b; Imm = imm; rd = r; rd_enable = en;
  endtask

  // One single-cycle op: drive after the edge, check mid-cycle.
  task automatic apply_alu(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] imm, input logic [4:0] r,
                           input logic en);
    logic [32:0] e;
    tick();
    drive(sel, op, a, b, imm, r, en);
    e = alu_ref(sel, op, a, b, imm);
    #4;
    chk("alu_stall", 32'(stall_req), 32'd0);
    chk("alu_data", rd_data_o, e[31:0]);
    chk("alu_en", 32'(rd_enable_o), 32'(e[32] & en));
    if (e[32]) chk("alu_addr", 32'(rd_addr_o), 32'(r));
  endtask

  // Muldiv presented at T0; stall through T32, result checked in T33.
  task automatic run_md(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input logic en);
    tick();
    drive(SEL_MULDIV, op, a, b, 32'd0, r, en);
    for (int t = 0; t <= 32; t++) begin
      #4;
      chk("md_stall", 32'(stall_req), 32'd1);
      chk("md_bubble", {rd_data_o[30:0], rd_enable_o}, 32'd0);
      tick();
    end
    #4;
    chk("md_done_stall", 32'(stall_req), 32'd0);
    chk("md_data", rd_data_o, md_ref(op, a, b));
    chk("md_en", 32'(rd_enable_o), 32'(en));
    chk("md_addr", 32'(rd_addr_o), 32'(r));
  endtask

  initial begin
    logic [7:0] mops [8];
    logic [2:0] s;
    logic [31:0] a, b;
    mops = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};

    rst = 1'b1;
    drive(SEL_ARITH, OP_ADD, 32'd5, 32'd6, 32'd0, 5'd3, 1'b1);
    tick();
    #4;
    chk("rst_data", rd_data_o, 32'd0);
    chk("rst_addr", 32'(rd_addr_o), 32'd0);
    chk("rst_en", 32'(rd_enable_o), 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    tick();
    rst = 1'b0;

    apply_alu(SEL_ARITH, OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'd0, 5'd1, 1'b1);
    chk("add_ovf", rd_data_o, 32'h8000_0000);
    apply_alu(SEL_SHIFT, OP_SRA, 32'h8000_0000, 32'd4, 32'd0, 5'd2, 1'b1);
    chk("sra", rd_data_o, 32'hF800_0000);
    apply_alu(SEL_ARITH, OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd3, 1'b1);
    chk("sltu", rd_data_o, 32'd1);
    apply_alu(SEL_NOP, OP_ADD, 32'd9, 32'd9, 32'd0, 5'd4, 1'b1);
    chk("nop_en", 32'(rd_enable_o), 32'd0);

    run_md(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1'b1);
    chk("mulh_m1", rd_data_o, 32'h0000_0000);
    run_md(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b1);
    chk("mulhu_m1", rd_data_o, 32'hFFFF_FFFE);
    run_md(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b1);
    chk("div_m7", rd_data_o, 32'hFFFF_FFFD);
    run_md(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd8, 1'b1);
    chk("rem_m7", rd_data_o, 32'hFFFF_FFFF);
    run_md(OP_DIVU, 32'd5, 32'd0, 5'd9, 1'b1);
    chk("divu_z", rd_data_o, 32'hFFFF_FFFF);
    run_md(OP_REMU, 32'd5, 32'd0, 5'd10, 1'b1);
    chk("remu_z", rd_data_o, 32'd5);
    run_md(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b1);
    chk("div_ovf", rd_data_o, 32'h8000_0000);
    run_md(OP_DIV, 32'hFFFF_FFF9, 32'd0, 5'd12, 1'b1);
    run_md(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b1);

    // Reset in the middle of a divide.
    tick();
    drive(SEL_MULDIV, OP_DIV, 32'd1000, 32'd7, 32'd0, 5'd14, 1'b1);
    for (int t = 0; t < 10; t++) begin
      #4;
      chk("pre_rst_stall", 32'(stall_req), 32'd1);
      tick();
    end
    rst = 1'b1;
    #4;
    chk("midrst_data", rd_data_o, 32'd0);
    chk("midrst_addr", 32'(rd_addr_o), 32'd0);
    chk("midrst_en", 32'(rd_enable_o), 32'd0);
    chk("midrst_stall", 32'(stall_req), 32'd0);
    tick();
    rst = 1'b0;
    drive(SEL_NOP, 8'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    #4;
    chk("postrst_stall", 32'(stall_req), 32'd0);
    chk("postrst_data", rd_data_o, 32'd0);
    chk("postrst_en", 32'(rd_enable_o), 32'd0);
    run_md(OP_MUL, 32'd3, 32'd4, 5'd15, 1'b1);
    chk("mul_3x4", rd_data_o, 32'd12);

    // ADD directly at T34, then a NOP to confirm no repeated write-back.
    apply_alu(SEL_ARITH, OP_ADD, 32'd20, 32'd22, 32'd0, 5'd16, 1'b1);
    chk("b2b_add", rd_data_o, 32'd42);
    apply_alu(SEL_NOP, 8'd0, 32'd0, 32'd0, 32'd0, 5'd16, 1'b1);

    for (int i = 0; i < 200; i++) begin
      s = 3'($urandom_range(0, 7));
      if (s == SEL_MULDIV) s = SEL_ARITH;
      apply_alu(s, 8'($urandom_range(0, 12)), $urandom, $urandom, $urandom,
                5'($urandom), 1'($urandom));
    end

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: ;
      endcase
      run_md(mops[$urandom_range(0, 7)], a, b, 5'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1)
        apply_alu(SEL_ARITH, OP_SUB, $urandom, $urandom, 32'd0, 5'($urandom), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ex.md
# ex

Execute stage of the five-stage pipeline, sitting directly downstream of the ID/EX pipeline register and feeding the EX/MEM register. It computes single-cycle ALU results combinationally. It also runs RV32M multiply/divide/remainder on an iterative radix-2 engine that requests a pipeline stall until the result is ready.

## Interface
- No parameters; widths come from shared defines: `RegLen`=32, `RegAddrLen`=5, `OpCodeLen`, `OpSelLen`.
- Clock/reset: one clock; reset is synchronous and active-high.
- clk  in  1  pipeline clock; all state changes on posedge.
- rst  in  1  synchronous, active-high (`ResetEnable`); sampled on posedge clk.
- reg1  in  32  operand 1.
- reg2  in  32  operand 2; decode has already substituted the immediate for I-type.
- Imm  in  32  immediate; used directly only by LUI.
- rd  in  5  destination register address.
- rd_enable  in  1  instruction writes rd.
- aluop  in  `OpCodeLen`  operation code.
- alusel  in  `OpSelLen`  class: LOGIC, SHIFT, ARITH, MULDIV, NOP.
- rd_data_o  out  32  result to EX/MEM.
- rd_addr_o  out  5  destination to EX/MEM.
- rd_enable_o  out  1  write-back valid to EX/MEM.
- stall_req  out  1  to pipeline control; freezes PC, IF/ID and ID/EX while high.

## Operation
- LOGIC: AND, OR, XOR.
- SHIFT: SLL, SRL, SRA, with amount reg2[4:0].
- ARITH: ADD, SUB, SLT (signed), SLTU, LUI (result = Imm).
- Non-MULDIV results are combinational from the inputs, with the outputs forwarded: rd_addr_o=rd, rd_enable_o=rd_enable.
- Unknown aluop/alusel, or NOP: rd_data_o=0, rd_enable_o=0.
- MULDIV ops are MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, following RV32M semantics.
- MULDIV FSM states: IDLE, BUSY, DONE.
  - IDLE: if alusel==MULDIV, then stall_req=1, operands are converted to magnitudes, result signs are latched, count is cleared, and next state is BUSY. Otherwise the block stays in IDLE.
  - BUSY: one iteration per cycle. Multiply is shift-add into a 64-bit accumulator; divide is restoring shift-subtract. When count==31, next state is DONE. stall_req=1 throughout.
  - DONE: sign correction applied; rd_data_o=selected result (low/high product, quotient, remainder); rd_enable_o=rd_enable; stall_req=0; next state IDLE.
- While stall_req=1, outputs are a bubble: rd_enable_o=0, rd_data_o=0.
- ID/EX holds its inputs stable while stalled. DONE does not re-trigger, because the new instruction arrives in the following cycle, which is IDLE.
- Divide by zero: quotient 0xFFFFFFFF; remainder = dividend.
- Signed overflow (0x80000000 / 0xFFFFFFFF): DIV result 0x80000000; REM result 0.
- Special cases take the full latency; there is no early exit.

## Timing
- Single-cycle ops: zero latency, combinational through to EX/MEM.
- MULDIV, with the instruction presented in cycle T0:
  - stall_req=1 in T0..T32 (33 cycles).
  - Result is valid in T33 with stall_req=0.
  - The next instruction is presented in T34.
- Reset, including mid-BUSY: FSM goes to IDLE, count=0, internal registers=0. While rst=1, all outputs are 0: rd_data_o, rd_addr_o, rd_enable_o, stall_req.
- Back-to-back MULDIV: the second starts in its own IDLE cycle (T34). There is no dead cycle beyond that.

## Structure
- Shared defines header holds RegLen, RegAddrLen, OpCodeLen, OpSelLen, ResetEnable, and all aluop/alusel encodings. The pipeline-control and decode stages include the same file.
- One sub-module, `muldiv_unit`, contains:
  - the FSM, 6-bit counter, 64-bit accumulator/remainder, latched signs and op;
  - ports start, operands, op, busy, done, result.
- `ex` contains the combinational ALU, the output mux, and the stall_req decode from start/busy.

## Test plan
- ADD 0x7FFFFFFF+1 -> rd_data_o=0x80000000 same cycle. SRA 0x80000000 by 4 -> 0xF8000000. SLTU 1 vs 0xFFFFFFFF -> 1.
- MULH 0xFFFFFFFF × 0xFFFFFFFF -> stall_req high T0..T32; T33 rd_data_o=0x00000000. MULHU of the same operands -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD (−3); REM of the same -> 0xFFFFFFFF (−1); both in T33.
- DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- rst asserted at T10 of a DIV -> next cycle stall_req=0, all outputs 0. A fresh MUL 3×4 then -> 12 at T33 of its own count.
- Back-to-back MUL then ADD -> ADD result appears exactly at T34 with rd_enable_o=1. No duplicate MUL write-back.
